// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction widths, opcode low bits and pc steps.
// Used by the fetch queue, the decompressor and the predictor.
package cpu_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned HALF_W = 16;

  // An instruction whose low two bits are 2'b11 is a full 32-bit encoding.
  localparam logic [1:0] OPC_LOW_32 = 2'b11;

  localparam int unsigned PC_STEP_16 = 2;
  localparam int unsigned PC_STEP_32 = 4;

endpackage

// File: rtl/cpu_ifq_hwbuf.sv
// Halfword circular buffer for the instruction fetch queue.
// Writes one or two halfwords per cycle, pops one or two, and reports the fill count.
// clr empties the buffer and overrides any write or pop in the same cycle.
module cpu_ifq_hwbuf
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH_HW = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           wr_en,
  input  logic                           wr_two,
  input  logic [2*HALF_W-1:0]            wr_data,
  input  logic                           rd_en,
  input  logic                           rd_two,
  output logic [HALF_W-1:0]              hw0,
  output logic [HALF_W-1:0]              hw1,
  output logic [$clog2(DEPTH_HW):0]      count
);

  localparam int unsigned PTR_W = $clog2(DEPTH_HW);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [HALF_W-1:0] mem_q [DEPTH_HW];
  logic [HALF_W-1:0] mem_d [DEPTH_HW];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_nx, rd_ptr_nx;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  push_n, pop_n;

  assign wr_ptr_nx = wr_ptr_q + PTR_W'(1);
  assign rd_ptr_nx = rd_ptr_q + PTR_W'(1);
  assign hw0       = mem_q[rd_ptr_q];
  assign hw1       = mem_q[rd_ptr_nx];
  assign count     = count_q;

  assign push_n = wr_en ? (wr_two ? CNT_W'(2) : CNT_W'(1)) : '0;
  assign pop_n  = rd_en ? (rd_two ? CNT_W'(2) : CNT_W'(1)) : '0;

  // Storage update; a single-halfword write carries the upper half of wr_data.
  always_comb begin
    mem_d = mem_q;
    if (wr_en && !clr) begin
      if (wr_two) begin
        mem_d[wr_ptr_q]  = wr_data[HALF_W-1:0];
        mem_d[wr_ptr_nx] = wr_data[2*HALF_W-1:HALF_W];
      end else begin
        mem_d[wr_ptr_q]  = wr_data[2*HALF_W-1:HALF_W];
      end
    end
  end

  // Pointer and count next state; count moves by the net push minus pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
      count_d  = count_q + push_n - pop_n;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cpu_ifq.sv
// Instruction fetch queue: issues word fetches, buffers halfwords, realigns and
// presents one instruction per cycle with its pc. Redirect flushes and refetches.
// Compressed (16-bit) support is built only when CPU_IFQ_RVC_EN is defined;
// otherwise every instruction is 32-bit and pops are always two halfwords.
module cpu_ifq
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH_HW = 8,
  parameter int unsigned PC_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              running,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              mem_en,
  output logic [PC_W-1:0]   mem_addr,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_compr
);

  localparam int unsigned CNT_W = $clog2(DEPTH_HW) + 1;

  logic [CNT_W-1:0]  count;
  logic [HALF_W-1:0] hw0, hw1;
  logic              inflight_q, inflight_d;
  logic              discard_q, discard_d;
  logic [PC_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic [PC_W-1:0]   head_pc_q, head_pc_d;
  logic [PC_W-1:0]   redirect_head_pc;
  logic              is_compr, have_inst, room, push, push_two, pop;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

`ifdef CPU_IFQ_RVC_EN
  logic drop_first_q, drop_first_d;

  assign is_compr         = (hw0[1:0] != OPC_LOW_32);
  assign push_two         = !drop_first_q;
  assign redirect_head_pc = {redirect_pc[PC_W-1:1], 1'b0};

  // A redirect into the upper half of a word keeps only that half of the first response.
  always_comb begin
    drop_first_d = drop_first_q;
    if (redirect) begin
      drop_first_d = redirect_pc[1];
    end else if (push) begin
      drop_first_d = 1'b0;
    end
  end

  // drop_first register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_first_q <= 1'b0;
    end else begin
      drop_first_q <= drop_first_d;
    end
  end
`else
  assign is_compr         = 1'b0;
  assign push_two         = 1'b1;
  assign redirect_head_pc = {redirect_pc[PC_W-1:2], 2'b00};
`endif

  // Issue only when the buffer can absorb this and any outstanding response.
  assign room      = (32'(count) + (inflight_q ? 32'd2 : 32'd0)) <= (DEPTH_HW - 32'd2);
  assign mem_en    = running & !redirect & room;
  assign mem_addr  = fetch_addr_q;

  assign push      = inflight_q & !discard_q & !redirect;
  assign have_inst = is_compr ? (count != '0) : (count >= CNT_W'(2));
  assign out_valid = have_inst & !redirect;
  assign pop       = out_valid & out_ready;

  assign out_pc    = head_pc_q;
  assign out_compr = out_valid & is_compr;
  assign out_inst  = !out_valid ? '0 :
                     is_compr   ? {16'h0000, hw0} : {hw1, hw0};

  cpu_ifq_hwbuf #(
    .DEPTH_HW (DEPTH_HW)
  ) u_hwbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (redirect),
    .wr_en   (push),
    .wr_two  (push_two),
    .wr_data (mem_rdata),
    .rd_en   (pop),
    .rd_two  (!is_compr),
    .hw0     (hw0),
    .hw1     (hw1),
    .count   (count)
  );

  // Fetch address, head pc and in-flight tracking; redirect wins over issue and pop.
  always_comb begin
    inflight_d   = mem_en;
    discard_d    = redirect & inflight_q;
    fetch_addr_d = fetch_addr_q;
    head_pc_d    = head_pc_q;
    if (redirect) begin
      fetch_addr_d = {redirect_pc[PC_W-1:2], 2'b00};
      head_pc_d    = redirect_head_pc;
    end else begin
      if (mem_en) begin
        fetch_addr_d = fetch_addr_q + PC_W'(PC_STEP_32);
      end
      if (pop) begin
        head_pc_d = head_pc_q + (is_compr ? PC_W'(PC_STEP_16) : PC_W'(PC_STEP_32));
      end
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q   <= 1'b0;
      discard_q    <= 1'b0;
      fetch_addr_q <= '0;
      head_pc_q    <= '0;
    end else begin
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
    end
  end

endmodule
